// File: rtl/memory.sv
// Memory-access stage: one instruction per cycle from execute, one data-bus
// transaction per load/store, registered result toward writeback.
// Optional feature: define MEM_MISALIGN_TRAP_EN to trap misaligned accesses
// (no bus transaction, error=1) instead of issuing them with a truncated strobe.
module memory (
  input  logic        clk,
  input  logic        reset,
  // execute -> memory
  input  logic        dataE_valid,
  input  logic [63:0] dataE_pc,
  input  logic [31:0] dataE_instr,
  input  logic [4:0]  dataE_dst,
  input  logic        dataE_memread,
  input  logic        dataE_memwrite,
  input  logic [1:0]  dataE_msize,
  input  logic        dataE_mem_unsigned,
  input  logic [63:0] dataE_result,
  input  logic [63:0] dataE_srcb,
  // memory -> writeback
  output logic        dataM_valid,
  output logic [63:0] dataM_pc,
  output logic [31:0] dataM_instr,
  output logic        dataM_memread,
  output logic        dataM_memwrite,
  output logic [1:0]  dataM_msize,
  output logic        dataM_mem_unsigned,
  output logic [4:0]  dataM_dst,
  output logic [63:0] dataM_result,
  output logic [63:0] dataM_memaddr,
  output logic        dataM_error,
  output logic        stallM,
  // data bus
  output logic        dreq_valid,
  output logic [63:0] dreq_addr,
  output logic [2:0]  dreq_size,
  output logic [7:0]  dreq_strobe,
  output logic [63:0] dreq_data,
  input  logic        dresp_addr_ok,
  input  logic        dresp_data_ok,
  input  logic [63:0] dresp_data
);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e      state_q, state_d;
  logic        m_valid_q, m_valid_d;
  logic [63:0] m_pc_q, m_pc_d;
  logic [31:0] m_instr_q, m_instr_d;
  logic        m_memread_q, m_memread_d;
  logic        m_memwrite_q, m_memwrite_d;
  logic [1:0]  m_msize_q, m_msize_d;
  logic        m_unsigned_q, m_unsigned_d;
  logic [4:0]  m_dst_q, m_dst_d;
  logic [63:0] m_result_q, m_result_d;
  logic [63:0] m_memaddr_q, m_memaddr_d;
  logic        m_error_q, m_error_d;
  logic        rq_valid_q, rq_valid_d;
  logic [63:0] rq_addr_q, rq_addr_d;
  logic [2:0]  rq_size_q, rq_size_d;
  logic [7:0]  rq_strobe_q, rq_strobe_d;
  logic [63:0] rq_data_q, rq_data_d;

  logic        is_mem;
  logic        trap;
  logic [3:0]  nbytes;
  logic [7:0]  st_mask;
  logic [7:0]  st_strobe;
  logic [63:0] st_data;
  logic [63:0] ld_raw;
  logic [63:0] ld_ext;

  // The bus accept handshake carries no information for this stage.
  logic unused_addr_ok;
  assign unused_addr_ok = dresp_addr_ok;

  assign is_mem = dataE_memread | dataE_memwrite;
  assign nbytes = 4'd1 << dataE_msize;

`ifdef MEM_MISALIGN_TRAP_EN
  assign trap = is_mem && ((dataE_result[3:0] & (nbytes - 4'd1)) != 4'd0);
`else
  assign trap = 1'b0;
`endif

  // Store alignment: byte mask and data shifted into the addressed lanes.
  always_comb begin
    st_mask   = 8'hFF >> (4'd8 - nbytes);
    st_strobe = st_mask << dataE_result[2:0];
    st_data   = dataE_srcb << {dataE_result[2:0], 3'b000};
  end

  // Load extraction from the latched request offset/size.
  always_comb begin
    ld_raw = dresp_data >> {rq_addr_q[2:0], 3'b000};
    case (m_msize_q)
      2'd0:    ld_ext = m_unsigned_q ? {56'd0, ld_raw[7:0]}  : {{56{ld_raw[7]}},  ld_raw[7:0]};
      2'd1:    ld_ext = m_unsigned_q ? {48'd0, ld_raw[15:0]} : {{48{ld_raw[15]}}, ld_raw[15:0]};
      2'd2:    ld_ext = m_unsigned_q ? {32'd0, ld_raw[31:0]} : {{32{ld_raw[31]}}, ld_raw[31:0]};
      default: ld_ext = ld_raw;
    endcase
  end

  // Next-state: accept in IDLE, wait for data_ok in BUSY.
  always_comb begin
    state_d      = state_q;
    m_valid_d    = 1'b0;
    m_pc_d       = m_pc_q;
    m_instr_d    = m_instr_q;
    m_memread_d  = m_memread_q;
    m_memwrite_d = m_memwrite_q;
    m_msize_d    = m_msize_q;
    m_unsigned_d = m_unsigned_q;
    m_dst_d      = m_dst_q;
    m_result_d   = m_result_q;
    m_memaddr_d  = m_memaddr_q;
    m_error_d    = m_error_q;
    rq_valid_d   = rq_valid_q;
    rq_addr_d    = rq_addr_q;
    rq_size_d    = rq_size_q;
    rq_strobe_d  = rq_strobe_q;
    rq_data_d    = rq_data_q;
    case (state_q)
      IDLE: begin
        if (dataE_valid) begin
          m_pc_d       = dataE_pc;
          m_instr_d    = dataE_instr;
          m_memread_d  = dataE_memread;
          m_memwrite_d = dataE_memwrite;
          m_msize_d    = dataE_msize;
          m_unsigned_d = dataE_mem_unsigned;
          m_dst_d      = dataE_dst;
          m_result_d   = dataE_result;
          m_memaddr_d  = dataE_result;
          m_error_d    = trap;
          if (is_mem && !trap) begin
            state_d     = BUSY;
            rq_valid_d  = 1'b1;
            rq_addr_d   = dataE_result;
            rq_size_d   = {1'b0, dataE_msize};
            rq_strobe_d = dataE_memwrite ? st_strobe : 8'd0;
            rq_data_d   = dataE_memwrite ? st_data : 64'd0;
          end else begin
            m_valid_d = 1'b1;
          end
        end
      end
      BUSY: begin
        if (dresp_data_ok) begin
          state_d    = IDLE;
          rq_valid_d = 1'b0;
          m_valid_d  = 1'b1;
          if (m_memread_q) m_result_d = ld_ext;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, output and request registers; reset drops everything at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      m_valid_q    <= 1'b0;
      m_pc_q       <= 64'd0;
      m_instr_q    <= 32'd0;
      m_memread_q  <= 1'b0;
      m_memwrite_q <= 1'b0;
      m_msize_q    <= 2'd0;
      m_unsigned_q <= 1'b0;
      m_dst_q      <= 5'd0;
      m_result_q   <= 64'd0;
      m_memaddr_q  <= 64'd0;
      m_error_q    <= 1'b0;
      rq_valid_q   <= 1'b0;
      rq_addr_q    <= 64'd0;
      rq_size_q    <= 3'd0;
      rq_strobe_q  <= 8'd0;
      rq_data_q    <= 64'd0;
    end else begin
      state_q      <= state_d;
      m_valid_q    <= m_valid_d;
      m_pc_q       <= m_pc_d;
      m_instr_q    <= m_instr_d;
      m_memread_q  <= m_memread_d;
      m_memwrite_q <= m_memwrite_d;
      m_msize_q    <= m_msize_d;
      m_unsigned_q <= m_unsigned_d;
      m_dst_q      <= m_dst_d;
      m_result_q   <= m_result_d;
      m_memaddr_q  <= m_memaddr_d;
      m_error_q    <= m_error_d;
      rq_valid_q   <= rq_valid_d;
      rq_addr_q    <= rq_addr_d;
      rq_size_q    <= rq_size_d;
      rq_strobe_q  <= rq_strobe_d;
      rq_data_q    <= rq_data_d;
    end
  end

  assign stallM             = (state_q == BUSY);
  assign dataM_valid        = m_valid_q;
  assign dataM_pc           = m_pc_q;
  assign dataM_instr        = m_instr_q;
  assign dataM_memread      = m_memread_q;
  assign dataM_memwrite     = m_memwrite_q;
  assign dataM_msize        = m_msize_q;
  assign dataM_mem_unsigned = m_unsigned_q;
  assign dataM_dst          = m_dst_q;
  assign dataM_result       = m_result_q;
  assign dataM_memaddr      = m_memaddr_q;
  assign dataM_error        = m_error_q;
  assign dreq_valid         = rq_valid_q;
  assign dreq_addr          = rq_addr_q;
  assign dreq_size          = rq_size_q;
  assign dreq_strobe        = rq_strobe_q;
  assign dreq_data          = rq_data_q;

endmodule

// File: tb/tb_memory.sv
// Self-checking bench for the memory stage: scoreboard of expected writeback
// records, bus responder driven inline, direct checks on the request bus.
module tb_memory;

  logic        clk = 1'b0;
  logic        reset;
  logic        dataE_valid;
  logic [63:0] dataE_pc;
  logic [31:0] dataE_instr;
  logic [4:0]  dataE_dst;
  logic        dataE_memread, dataE_memwrite;
  logic [1:0]  dataE_msize;
  logic        dataE_mem_unsigned;
  logic [63:0] dataE_result, dataE_srcb;
  logic        dataM_valid;
  logic [63:0] dataM_pc;
  logic [31:0] dataM_instr;
  logic        dataM_memread, dataM_memwrite;
  logic [1:0]  dataM_msize;
  logic        dataM_mem_unsigned;
  logic [4:0]  dataM_dst;
  logic [63:0] dataM_result, dataM_memaddr;
  logic        dataM_error;
  logic        stallM;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_addr_ok, dresp_data_ok;
  logic [63:0] dresp_data;

  always #5 clk = ~clk;

  memory dut (
    .clk(clk), .reset(reset),
    .dataE_valid(dataE_valid), .dataE_pc(dataE_pc), .dataE_instr(dataE_instr),
    .dataE_dst(dataE_dst), .dataE_memread(dataE_memread), .dataE_memwrite(dataE_memwrite),
    .dataE_msize(dataE_msize), .dataE_mem_unsigned(dataE_mem_unsigned),
    .dataE_result(dataE_result), .dataE_srcb(dataE_srcb),
    .dataM_valid(dataM_valid), .dataM_pc(dataM_pc), .dataM_instr(dataM_instr),
    .dataM_memread(dataM_memread), .dataM_memwrite(dataM_memwrite),
    .dataM_msize(dataM_msize), .dataM_mem_unsigned(dataM_mem_unsigned),
    .dataM_dst(dataM_dst), .dataM_result(dataM_result), .dataM_memaddr(dataM_memaddr),
    .dataM_error(dataM_error), .stallM(stallM),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data)
  );

  typedef struct packed {
    logic [63:0] pc;
    logic [4:0]  dst;
    logic [63:0] result;
    logic [63:0] memaddr;
    logic        error;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Every writeback-valid cycle retires exactly one scoreboard entry.
  always @(negedge clk) begin
    if (!reset && dataM_valid) begin
      if (sb.size() == 0) chk("unexpected_valid", dataM_valid, 1'b0);
      else begin
        mon_e = sb.pop_front();
        chk("m_pc",      dataM_pc,      mon_e.pc);
        chk("m_dst",     dataM_dst,     64'(mon_e.dst));
        chk("m_result",  dataM_result,  mon_e.result);
        chk("m_memaddr", dataM_memaddr, mon_e.memaddr);
        chk("m_error",   dataM_error,   64'(mon_e.error));
      end
    end
  end

  task automatic set_e(input logic [63:0] pc, input logic [4:0] dst, input logic rd,
                       input logic wr, input logic [1:0] msz, input logic uns,
                       input logic [63:0] res, input logic [63:0] srcb);
    dataE_valid = 1'b1; dataE_pc = pc; dataE_instr = pc[31:0] ^ 32'h13;
    dataE_dst = dst; dataE_memread = rd; dataE_memwrite = wr;
    dataE_msize = msz; dataE_mem_unsigned = uns; dataE_result = res; dataE_srcb = srcb;
  endtask

  // One ALU instruction accepted at the next edge; leaves dataE driven.
  task automatic alu(input logic [63:0] pc, input logic [4:0] dst, input logic [63:0] res);
    set_e(pc, dst, 1'b0, 1'b0, 2'd0, 1'b0, res, 64'd0);
    sb.push_back('{pc, dst, res, res, 1'b0});
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    dataE_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Memory op held upstream while stalled; data_ok asserted in BUSY cycle 'waits'.
  task automatic mem_op(input logic [63:0] pc, input logic [4:0] dst, input logic rd,
                        input logic wr, input logic [1:0] msz, input logic uns,
                        input logic [63:0] addr, input logic [63:0] srcb, input int waits,
                        input logic [63:0] rdata, input logic [63:0] exp_res,
                        input logic [7:0] exp_strobe, input logic [63:0] exp_data);
    set_e(pc, dst, rd, wr, msz, uns, addr, srcb);
    sb.push_back('{pc, dst, exp_res, addr, 1'b0});
    @(posedge clk); #1;
    for (int i = 0; i < waits; i++) begin
      dresp_addr_ok = (i == 0);
      if (i == waits - 1) begin
        dresp_data_ok = 1'b1;
        dresp_data    = rdata;
      end
      @(negedge clk);
      chk("dreq_valid",  dreq_valid, 1'b1);
      chk("stall_busy",  stallM, 1'b1);
      chk("m_valid_busy", dataM_valid, 1'b0);
      chk("dreq_addr",   dreq_addr, addr);
      chk("dreq_size",   dreq_size, {61'd0, 1'b0, msz});
      chk("dreq_strobe", dreq_strobe, exp_strobe);
      if (wr) chk("dreq_data", dreq_data, exp_data);
      @(posedge clk); #1;
    end
    dresp_data_ok = 1'b0; dresp_addr_ok = 1'b0; dresp_data = 64'd0;
    dataE_valid = 1'b0;
    @(negedge clk);
    chk("m_valid_done", dataM_valid, 1'b1);
    chk("dreq_drop",    dreq_valid, 1'b0);
    chk("stall_done",   stallM, 1'b0);
  endtask

  initial begin
    logic [63:0] rnd;
    dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = 64'd0;
    reset = 1'b1;
    // Reset held with a valid ADD presented.
    set_e(64'h100, 5'd1, 1'b0, 1'b0, 2'd0, 1'b0, 64'h5, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_m_valid", dataM_valid, 1'b0);
    chk("rst_dreq",    dreq_valid, 1'b0);
    chk("rst_stall",   stallM, 1'b0);
    chk("rst_result",  dataM_result, 64'd0);
    reset = 1'b0;
    sb.push_back('{64'h100, 5'd1, 64'h5, 64'h5, 1'b0});
    @(posedge clk); #1;
    dataE_valid = 1'b0;
    @(negedge clk);
    chk("add_lat1", dataM_valid, 1'b1);
    idle(1);

    // Back-to-back ALU ops, then LB with no bubble, 3 BUSY cycles.
    alu(64'h200, 5'd2, 64'h1111);
    alu(64'h204, 5'd3, 64'h2222);
    alu(64'h208, 5'd4, 64'h3333);
    mem_op(64'h20C, 5'd5, 1'b1, 1'b0, 2'd0, 1'b0, 64'h1003, 64'd0, 3,
           64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80, 8'h00, 64'd0);
    // LWU zero-wait.
    mem_op(64'h210, 5'd6, 1'b1, 1'b0, 2'd2, 1'b1, 64'h2004, 64'd0, 1,
           64'hDEAD_BEEF_0000_0000, 64'h0000_0000_DEAD_BEEF, 8'h00, 64'd0);
    // SH into lanes 2..3.
    mem_op(64'h214, 5'd0, 1'b0, 1'b1, 2'd1, 1'b0, 64'h3002, 64'h1234, 2,
           64'd0, 64'h3002, 8'h0C, 64'h0000_0000_1234_0000);
    // SD aligned, random data.
    rnd = {$urandom, $urandom};
    mem_op(64'h218, 5'd0, 1'b0, 1'b1, 2'd3, 1'b0, 64'h4000, rnd, 1,
           64'd0, 64'h4000, 8'hFF, rnd);
    // LH signed from the top halfword.
    mem_op(64'h21C, 5'd7, 1'b1, 1'b0, 2'd1, 1'b0, 64'h5006, 64'd0, 2,
           64'h8001_0000_0000_0000, 64'hFFFF_FFFF_FFFF_8001, 8'h00, 64'd0);
    idle(1);

    // Reset while BUSY abandons the load.
    set_e(64'h300, 5'd8, 1'b1, 1'b0, 2'd3, 1'b0, 64'h6000, 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("busy_pre_rst", dreq_valid, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("rst_busy_dreq",  dreq_valid, 1'b0);
    chk("rst_busy_stall", stallM, 1'b0);
    chk("rst_busy_valid", dataM_valid, 1'b0);
    dataE_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    alu(64'h304, 5'd9, 64'hABCD);
    idle(2);

    // Misaligned word access.
`ifdef MEM_MISALIGN_TRAP_EN
    set_e(64'h400, 5'd10, 1'b1, 1'b0, 2'd2, 1'b0, 64'h1002, 64'd0);
    sb.push_back('{64'h400, 5'd10, 64'h1002, 64'h1002, 1'b1});
    @(posedge clk); #1;
    dataE_valid = 1'b0;
    @(negedge clk);
    chk("trap_no_dreq", dreq_valid, 1'b0);
    chk("trap_stall",   stallM, 1'b0);
    chk("trap_valid",   dataM_valid, 1'b1);
`else
    mem_op(64'h400, 5'd0, 1'b0, 1'b1, 2'd2, 1'b0, 64'h1002, 64'hCAFE_BABE, 1,
           64'd0, 64'h1002, 8'h3C, 64'h0000_CAFE_BABE_0000);
`endif
    idle(3);
    chk("sb_drain", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
